// File: rtl/count_checker.sv
// Receive-side checker for a free-running up-counter stream: acquires lock on
// the +1 sequence, flags breaks while locked, and drops lock after repeated misses.
module count_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSE_COUNT = 2,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     in,
  output logic                 locked,
  output logic                 error,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_WIDTH-1:0] errorCount,
  output logic [1:0]           state
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSE_COUNT + 1);
  localparam logic [RUN_W-1:0]  LAST_RUN  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] LAST_MISS = MISS_W'(LOSE_COUNT - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    SYNC    = 2'd1,
    LOCKED  = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t              state_q;
  logic [RUN_W-1:0]    run_q;
  logic [MISS_W-1:0]   miss_q;
  logic                match;
  logic [WIDTH-1:0]    in_inc;
  logic [WIDTH-1:0]    exp_inc;

  // Next-value arithmetic wraps naturally at the register width.
  assign match   = (in == expected);
  assign in_inc  = in + WIDTH'(1);
  assign exp_inc = expected + WIDTH'(1);
  assign state   = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      locked     <= 1'b0;
      error      <= 1'b0;
      expected   <= '0;
      errorCount <= '0;
      run_q      <= '0;
      miss_q     <= '0;
    end else begin
      error <= 1'b0;
      case (state_q)
        HUNT: begin
          if (valid) begin
            expected <= in_inc;
            run_q    <= '0;
            state_q  <= SYNC;
          end
        end

        SYNC: begin
          if (valid) begin
            expected <= in_inc;
            if (match) begin
              run_q <= run_q + RUN_W'(1);
              if (run_q == LAST_RUN) begin
                state_q <= LOCKED;
                locked  <= 1'b1;
                miss_q  <= '0;
              end
            end else begin
              run_q <= '0;
            end
          end
        end

        LOCKED: begin
          if (valid) begin
            if (match) begin
              expected <= in_inc;
              miss_q   <= '0;
            end else begin
              // Flywheel: keep counting from our own prediction, not the bad value.
              error    <= 1'b1;
              expected <= exp_inc;
              miss_q   <= miss_q + MISS_W'(1);
              if (errorCount != {ERR_WIDTH{1'b1}})
                errorCount <= errorCount + ERR_WIDTH'(1);
              if (miss_q == LAST_MISS) begin
                state_q <= HUNT;
                locked  <= 1'b0;
                run_q   <= '0;
              end
            end
          end
        end

        default: begin
          state_q <= HUNT;
          locked  <= 1'b0;
          run_q   <= '0;
          miss_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Directed self-checking bench for count_checker: default instance plus a
// small-counter instance for saturation.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       reset, valid;
  logic [7:0] din;
  logic       locked, error;
  logic [7:0] expected;
  logic [15:0] err_cnt;
  logic [1:0] state;

  logic       reset2, valid2;
  logic [7:0] din2;
  logic       locked2, error2;
  logic [7:0] expected2;
  logic [1:0] err_cnt2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_checker dut (
    .clk(clk), .reset(reset), .valid(valid), .in(din),
    .locked(locked), .error(error), .expected(expected),
    .errorCount(err_cnt), .state(state)
  );

  count_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSE_COUNT(8), .ERR_WIDTH(2)) sat (
    .clk(clk), .reset(reset2), .valid(valid2), .in(din2),
    .locked(locked2), .error(error2), .expected(expected2),
    .errorCount(err_cnt2), .state(state2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    reset = r; valid = v; din = d;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic r, input logic v, input logic [7:0] d);
    reset2 = r; valid2 = v; din2 = d;
    @(posedge clk); #1;
  endtask

  task automatic chk_main(input string tag, input logic [1:0] st, input logic lk,
                          input logic er, input logic [7:0] ex, input logic [15:0] ec);
    chk({tag, ".state"},    32'(state),    32'(st));
    chk({tag, ".locked"},   32'(locked),   32'(lk));
    chk({tag, ".error"},    32'(error),    32'(er));
    chk({tag, ".expected"}, 32'(expected), 32'(ex));
    chk({tag, ".errcnt"},   32'(err_cnt),  32'(ec));
  endtask

  initial begin
    reset2 = 1'b1; valid2 = 1'b0; din2 = 8'd0;

    // Reset state
    step(1'b1, 1'b0, 8'd0);
    chk_main("reset", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // 1: lock back-to-back on 10..14
    step(1'b0, 1'b1, 8'd10); chk_main("lock.10", 2'd1, 1'b0, 1'b0, 8'd11, 16'd0);
    step(1'b0, 1'b1, 8'd11); chk_main("lock.11", 2'd1, 1'b0, 1'b0, 8'd12, 16'd0);
    step(1'b0, 1'b1, 8'd12); chk_main("lock.12", 2'd1, 1'b0, 1'b0, 8'd13, 16'd0);
    step(1'b0, 1'b1, 8'd13); chk_main("lock.13", 2'd1, 1'b0, 1'b0, 8'd14, 16'd0);
    step(1'b0, 1'b1, 8'd14); chk_main("lock.14", 2'd2, 1'b1, 1'b0, 8'd15, 16'd0);

    // 3: single glitch while locked
    for (int v = 15; v < 20; v++) step(1'b0, 1'b1, 8'(v));
    step(1'b0, 1'b1, 8'd20); chk_main("glitch.20", 2'd2, 1'b1, 1'b0, 8'd21, 16'd0);
    step(1'b0, 1'b1, 8'd21);
    step(1'b0, 1'b1, 8'd99); chk_main("glitch.99", 2'd2, 1'b1, 1'b1, 8'd23, 16'd1);
    step(1'b0, 1'b1, 8'd23); chk_main("glitch.23", 2'd2, 1'b1, 1'b0, 8'd24, 16'd1);

    // 4: loss of lock from a fresh lock at expected=30
    step(1'b1, 1'b0, 8'd0);
    for (int v = 25; v < 30; v++) step(1'b0, 1'b1, 8'(v));
    chk_main("lose.pre", 2'd2, 1'b1, 1'b0, 8'd30, 16'd0);
    step(1'b0, 1'b1, 8'd77); chk_main("lose.77", 2'd2, 1'b1, 1'b1, 8'd31, 16'd1);
    step(1'b0, 1'b1, 8'd78); chk_main("lose.78", 2'd0, 1'b0, 1'b1, 8'd32, 16'd2);
    for (int v = 79; v < 83; v++) step(1'b0, 1'b1, 8'(v));
    chk_main("relock.82", 2'd1, 1'b0, 1'b0, 8'd83, 16'd2);
    step(1'b0, 1'b1, 8'd83); chk_main("relock.83", 2'd2, 1'b1, 1'b0, 8'd84, 16'd2);

    // 2: wrap 252..255,0,1
    step(1'b1, 1'b0, 8'd0);
    for (int v = 252; v < 256; v++) step(1'b0, 1'b1, 8'(v));
    chk_main("wrap.255", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    step(1'b0, 1'b1, 8'd0); chk_main("wrap.0", 2'd2, 1'b1, 1'b0, 8'd1, 16'd0);
    step(1'b0, 1'b1, 8'd1); chk_main("wrap.1", 2'd2, 1'b1, 1'b0, 8'd2, 16'd0);

    // 5: valid gaps, then reset colliding with valid
    step(1'b0, 1'b1, 8'd2);  chk_main("gap.v1", 2'd2, 1'b1, 1'b0, 8'd3, 16'd0);
    step(1'b0, 1'b0, 8'd55); chk_main("gap.v0", 2'd2, 1'b1, 1'b0, 8'd3, 16'd0);
    step(1'b0, 1'b1, 8'd3);  chk_main("gap.v1b", 2'd2, 1'b1, 1'b0, 8'd4, 16'd0);
    step(1'b1, 1'b1, 8'd4);  chk_main("rst.valid", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    step(1'b0, 1'b1, 8'd200); chk_main("rst.hunt", 2'd1, 1'b0, 1'b0, 8'd201, 16'd0);
    step(1'b0, 1'b0, 8'd0);

    // 6: saturation on the 2-bit error counter
    step2(1'b1, 1'b0, 8'd0);
    for (int v = 0; v < 5; v++) step2(1'b0, 1'b1, 8'(v));
    chk("sat.locked", 32'(locked2), 32'd1);
    chk("sat.exp0",   32'(expected2), 32'd5);
    for (int k = 0; k < 5; k++) begin
      step2(1'b0, 1'b1, 8'd100);
      chk($sformatf("sat.err%0d", k), 32'(error2), 32'd1);
      chk($sformatf("sat.cnt%0d", k), 32'(err_cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
      chk($sformatf("sat.exp%0d", k + 1), 32'(expected2), 32'(6 + k));
    end
    chk("sat.locked_end", 32'(locked2), 32'd1);
    step2(1'b0, 1'b0, 8'd0);
    chk("sat.idle_err", 32'(error2), 32'd0);
    chk("sat.idle_cnt", 32'(err_cnt2), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
